// File: rtl/mult_bus_pkg.sv
// Shared types and defaults for the multiplier bus initiator and its helpers.
package mult_bus_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_LSB,
        WAIT_MSB,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_PROTO   = 2'b10
    } status_t;

endpackage

// File: rtl/mult_bus_timeout.sv
// Clear/enable cycle counter; expire is high once the count reaches TIMEOUT_CYC-1.
module mult_bus_timeout #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] count_reg;

    assign expire = (count_reg == CNT_W'(TIMEOUT_CYC - 1));

    // Saturate at the expiry value so a late wrap can never hide a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mult_bus_host.sv
// Initiator for the shared 8-bit Multiplier bus: sends an operand pair, collects the product.
// Optional result self-check is enabled by defining MULT_BUS_HOST_CHECK_EN.
module mult_bus_host
    import mult_bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic [1:0]          rsp_status,
    output logic                start,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_oe,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic                lsb_out,
    input  logic                msb_out,
    input  logic                done,
    output logic                chk_mismatch
);

    state_t            state_reg;
    logic [DATA_W-1:0] op_b_reg;
    logic              lsb_take;
    logic              timer_clr;
    logic              timer_expire;

    assign lsb_take  = (state_reg == WAIT_LSB) && lsb_out && !msb_out;
    assign timer_clr = !((state_reg == WAIT_LSB) || (state_reg == WAIT_MSB)) || lsb_take;

    mult_bus_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (1'b1),
        .expire (timer_expire)
    );

`ifdef MULT_BUS_HOST_CHECK_EN
    logic [DATA_W-1:0] op_a_reg;
    logic              chk_mismatch_reg;
    logic              prod_bad;

    assign prod_bad = ({bus_in, rsp_result[DATA_W-1:0]} !=
                       ((2*DATA_W)'(op_a_reg) * (2*DATA_W)'(op_b_reg)));
    assign chk_mismatch = chk_mismatch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg         <= '0;
            chk_mismatch_reg <= 1'b0;
        end else begin
            chk_mismatch_reg <= 1'b0;
            if (state_reg == IDLE && req_valid && req_ready) begin
                op_a_reg <= req_a;
            end
            if (state_reg == WAIT_MSB && msb_out && done) begin
                chk_mismatch_reg <= prod_bad;
            end
        end
    end
`else
    assign chk_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_status <= ST_OK;
            start      <= 1'b0;
            bus_out    <= '0;
            bus_oe     <= 1'b0;
            op_b_reg   <= '0;
        end else begin
            start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        op_b_reg   <= req_b;
                        rsp_result <= '0;
                        rsp_status <= ST_OK;
                        start      <= 1'b1;
                        bus_oe     <= 1'b1;
                        bus_out    <= req_a;
                        state_reg  <= SEND_A;
                    end
                end
                SEND_A: begin
                    bus_out   <= op_b_reg;
                    state_reg <= SEND_B;
                end
                SEND_B: begin
                    bus_oe    <= 1'b0;
                    bus_out   <= '0;
                    state_reg <= WAIT_LSB;
                end
                WAIT_LSB: begin
                    if (msb_out) begin
                        rsp_status <= ST_PROTO;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end else if (lsb_out) begin
                        rsp_result[DATA_W-1:0] <= bus_in;
                        state_reg              <= WAIT_MSB;
                    end else if (timer_expire) begin
                        rsp_status <= ST_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                WAIT_MSB: begin
                    if (msb_out && done) begin
                        rsp_result[2*DATA_W-1:DATA_W] <= bus_in;
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end else if (msb_out || lsb_out) begin
                        rsp_status <= ST_PROTO;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end else if (timer_expire) begin
                        rsp_status <= ST_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_bus_host.md
Name: mult_bus_host

Overview:
- Synthesizable initiator for the shared 8-bit Multiplier bus (start, databus, lsb_out, msb_out, done).
- Accepts an operand pair on a valid/ready request port, drives start plus both operands onto the bus, then releases the bus.
- Captures the low and high result bytes the Multiplier drives back, and returns a 16-bit product with status on a valid/ready response port.
- Sits between the processing logic and the Multiplier; the top level resolves the tri-state databus from bus_out/bus_oe.

Parameters:
- DATA_W, 8, operand and bus byte width; result is 2*DATA_W.
- TIMEOUT_CYC, 64, maximum cycles to wait for each result strobe; must be ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  DATA_W  operand 1.
- req_b  in  DATA_W  operand 2.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  2*DATA_W  product {msb byte, lsb byte}.
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 PROTO_ERR.
- start  out  1  Multiplier start pulse.
- bus_out  out  DATA_W  value driven onto databus.
- bus_oe  out  1  databus drive enable.
- bus_in  in  DATA_W  resolved databus value.
- lsb_out  in  1  Multiplier strobe: low byte is on bus.
- msb_out  in  1  Multiplier strobe: high byte is on bus.
- done  in  1  Multiplier completion; must coincide with msb_out.
- chk_mismatch  out  1  one-cycle pulse on a self-check failure; tied 0 when the optional feature is absent.

Behaviour:
- Reset values (while rst_n=0): state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_status=00, start=0, bus_out=0, bus_oe=0, chk_mismatch=0, timer=0.
- req_ready is registered and equals 1 only in IDLE. It goes high on the first edge after rst_n deasserts.
- All outputs are registered.
- State machine:
  - IDLE: on req_valid&req_ready, latch req_a/req_b, clear the captured result to 0, and go to SEND_A.
  - SEND_A (1 cycle): start=1, bus_oe=1, bus_out=A. Next state SEND_B.
  - SEND_B (1 cycle): start=0, bus_oe=1, bus_out=B. Next state WAIT_LSB.
  - WAIT_LSB: bus_oe=0, bus_out=0, timer counts from 0.
    - lsb_out alone: capture bus_in into result[DATA_W-1:0], restart the timer, go to WAIT_MSB.
    - msb_out, or lsb_out&msb_out together: status PROTO_ERR, go to RESP.
    - timer reaches TIMEOUT_CYC-1: status TIMEOUT, go to RESP.
  - WAIT_MSB:
    - msb_out&done: capture bus_in into the high byte, status OK, go to RESP.
    - msb_out without done, or lsb_out again: status PROTO_ERR, go to RESP.
    - Timer expiry: status TIMEOUT, go to RESP.
  - RESP: rsp_valid=1; rsp_result and rsp_status held stable. On rsp_ready, go to IDLE with rsp_valid=0.
- A stray done outside WAIT_MSB is ignored.
- Bytes not captured read as 0.
- Latency: request accepted at edge k; start is high in cycle k+1; bus is released from cycle k+3. With Multiplier strobes at cycles L and M, rsp_valid is high from cycle M+1.
- req_valid during a busy transaction waits; there is no queuing.
- Reset mid-operation: immediate return to the reset values. Any in-flight transaction is discarded with no response.

Optional Feature:
- Macro: MULT_BUS_HOST_CHECK_EN.
- Defined: on entry to RESP with status OK, compare the captured result against req_a*req_b (full 2*DATA_W width). Pulse chk_mismatch for one cycle if they differ; the response is still delivered unchanged.
- Undefined: no multiplier is inferred and chk_mismatch is constant 0.

Decomposition:
- Package mult_bus_pkg:
  - DATA_W default.
  - State enum (IDLE, SEND_A, SEND_B, WAIT_LSB, WAIT_MSB, RESP).
  - Status codes (ST_OK, ST_TIMEOUT, ST_PROTO).
- One sub-module, mult_bus_timeout: a clear/enable counter with an expire output, sized $clog2(TIMEOUT_CYC).

Test Plan:
- 0x03 × 0x05, Multiplier model returns lsb 0x0F and msb 0x00 with done → start high one cycle with bus 0x03, next cycle bus 0x05, then rsp_result=0x000F, status 00.
- 0xFF × 0xFF, model returns 0x01 then 0xFE → rsp_result=0xFE01, status 00, chk_mismatch=0.
- Model never strobes → exactly TIMEOUT_CYC cycles after bus release: rsp_valid=1, status 01, rsp_result=0x0000.
- Model asserts msb_out before lsb_out → status 10; then a second transaction 0x02 × 0x04 completes with result 0x0008.
- rsp_ready held 0 for 5 cycles with req_valid held high → rsp_valid and result stable, req_ready=0; the next request is accepted one cycle after the handshake.
- Reset pulsed in WAIT_LSB → all outputs at reset values, no response. With MULT_BUS_HOST_CHECK_EN, model returning 0x0010 for 3 × 5 → chk_mismatch pulses once.
